wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of writeback requesters (fixed at 2 for this revision).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports wb0_valid/wb1_valid  input  1  requester 0 (ALU) / requester 1 (LSU) has a writeback pending.
REQ-005 SHALL have ports wb0_rd/wb1_rd  input  5  destination register of each requester.
REQ-006 SHALL have ports wb0_data/wb1_data  input  32  writeback data of each requester.
REQ-007 SHALL have ports wb0_ready/wb1_ready  output  1  combinational grant; transfer occurs when valid and ready are both high.
REQ-008 SHALL have ports issue_valid  input  1, issue_rd  input  5  decode marks a destination register as pending.
REQ-009 SHALL have ports rs1/rs2  input  5  source registers queried by decode.
REQ-010 SHALL have port hazard  output  1  combinational; high when rs1 or rs2 is pending.
REQ-011 SHALL have ports rf_we  output  1, rf_waddr  output  5, rf_wdata  output  32  registered drive of the register-file write port.

Function
REQ-012 SHALL grant at most one requester per cycle; the ready of a non-valid requester is low.
REQ-013 SHALL grant the sole valid requester when only one is valid.
REQ-014 SHALL, when both are valid, grant the requester not granted most recently (round-robin); last_grant updates only on a completed transfer.
REQ-015 SHALL drive rf_we=1, rf_waddr=granted rd, rf_wdata=granted data in the cycle after the transfer (1-cycle latency), rf_we=0 otherwise.
REQ-016 SHALL accept a transfer with rd=0 (ready high) but keep rf_we=0 that cycle (x0 never written).
REQ-017 SHALL keep a 32-bit pending scoreboard; issue_valid with issue_rd!=0 sets bit issue_rd at the clock edge.
REQ-018 SHALL clear the scoreboard bit of the granted rd on a completed transfer.
REQ-019 SHALL, on set and clear of the same register in one cycle, leave the bit set (new pending writer wins).
REQ-020 SHALL never set bit 0; hazard for rs1=0 or rs2=0 contributes 0.
REQ-021 SHALL compute hazard from the current scoreboard only (no bypass of same-cycle clears).
REQ-022 SHALL hold rf_waddr/rf_wdata at last written values when rf_we=0.

Reset
REQ-023 SHALL, while rstn=0 at a clock edge, clear the scoreboard, set rf_we=0, rf_waddr=0, rf_wdata=0, last_grant=1 (so requester 0 wins the first tie).
REQ-024 SHALL discard any transfer presented in a reset cycle; ready is forced low while rstn=0.
REQ-025 SHALL resume arbitration on the first edge with rstn=1 with no residual state.

Structure
REQ-026 SHALL place REG_ADDR_W=5, XLEN=32, NUM_REGS=32 and the requester index constants in the shared cpu package.
REQ-027 SHALL implement the scoreboard as sub-module wb_scoreboard (set/clear/query ports); arbitration and write-port register stay in wb_arbiter.

Verification
REQ-028 SHALL test: after reset, wb0 and wb1 both valid every cycle, rd 3/4 -> grants alternate 0,1,0,1; rf_we each following cycle with rd 3,4,3,4.
REQ-029 SHALL test: wb1_valid alone, rd=7, data=0xDEADBEEF -> wb1_ready=1 same cycle; next cycle rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF.
REQ-030 SHALL test: wb0 transfer with rd=0 -> wb0_ready=1, rf_we stays 0, rf_wdata unchanged.
REQ-031 SHALL test: issue rd=5, then rs1=5 -> hazard=1; wb transfer rd=5 -> hazard=0 the cycle after; issue rd=5 and transfer rd=5 same cycle -> hazard stays 1.
REQ-032 SHALL test: scoreboard bits 2,9 set, rstn=0 for one cycle mid-transfer -> no rf_we, hazard=0 for rs1=2/rs2=9, first tie after reset granted to wb0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared cpu constants and types for the writeback path.
// Register-file geometry, requester indices and the writeback request bundle.
package wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_LSU = 1'b1
  } last_e;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    xlen_t     data;
  } wb_req_t;

  function automatic logic nz(reg_addr_t a);
    return a != '0;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-writer scoreboard, one bit per architectural register.
// Set wins over clear on the same register; x0 is never pending.
module wb_scoreboard
  import wb_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rstn,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  output logic      hazard
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;

  // next scoreboard: clear the retiring writer, then mark the new one
  always_comb begin
    pend_d = pend_q;
    if (clr_en)
      pend_d[clr_addr] = 1'b0;
    if (set_en && nz(set_addr))
      pend_d[set_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // scoreboard register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn)
      pend_q <= '0;
    else
      pend_q <= pend_d;
  end

  // query the registered state only; same-cycle clears are not bypassed
  always_comb begin
    hazard = (nz(rs1) && pend_q[rs1])
          || (nz(rs2) && pend_q[rs2]);
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester writeback arbiter with round-robin tie break.
// Drives the register-file write port one cycle after each transfer.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wb0_valid,
  input  logic [REG_ADDR_W-1:0] wb0_rd,
  input  logic [XLEN-1:0]       wb0_data,
  output logic                  wb0_ready,
  input  logic                  wb1_valid,
  input  logic [REG_ADDR_W-1:0] wb1_rd,
  input  logic [XLEN-1:0]       wb1_data,
  output logic                  wb1_ready,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  hazard,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
);

  wb_req_t         req [NREQ];
  logic [NREQ-1:0] ready;
  logic            xfer;
  reg_addr_t       g_rd;
  xlen_t           g_data;
  last_e           last_q;
  last_e           last_d;

  assign req[REQ_ALU] = '{valid: wb0_valid, rd: wb0_rd, data: wb0_data};
  assign req[REQ_LSU] = '{valid: wb1_valid, rd: wb1_rd, data: wb1_data};

  // grant: sole valid requester wins, ties go to the one not granted last
  always_comb begin
    ready = '0;
    if (rstn) begin
      unique case (1'b1)
        req[REQ_ALU].valid && req[REQ_LSU].valid: begin
          if (last_q == LAST_ALU)
            ready[REQ_LSU] = 1'b1;
          else
            ready[REQ_ALU] = 1'b1;
        end
        req[REQ_ALU].valid && !req[REQ_LSU].valid:
          ready[REQ_ALU] = 1'b1;
        !req[REQ_ALU].valid && req[REQ_LSU].valid:
          ready[REQ_LSU] = 1'b1;
        default: ;
      endcase
    end
  end

  assign wb0_ready = ready[REQ_ALU];
  assign wb1_ready = ready[REQ_LSU];
  assign xfer      = |ready;

  // route the granted request onto the write path
  always_comb begin
    g_rd   = req[REQ_ALU].rd;
    g_data = req[REQ_ALU].data;
    if (ready[REQ_LSU]) begin
      g_rd   = req[REQ_LSU].rd;
      g_data = req[REQ_LSU].data;
    end
  end

  // last-grant next state moves only on a completed transfer
  always_comb begin
    last_d = last_q;
    if (xfer)
      last_d = ready[REQ_LSU] ? LAST_LSU : LAST_ALU;
  end

  // last-grant register; reset makes the ALU win the first tie
  always_ff @(posedge clk) begin
    if (!rstn)
      last_q <= LAST_LSU;
    else
      last_q <= last_d;
  end

  // register-file write port; address/data hold when idle or rd=x0
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= xfer && nz(g_rd);
      if (xfer && nz(g_rd)) begin
        rf_waddr <= g_rd;
        rf_wdata <= g_data;
      end
    end
  end

  wb_scoreboard u_sb (
    .clk      (clk),
    .rstn     (rstn),
    .set_en   (issue_valid),
    .set_addr (issue_rd),
    .clr_en   (xfer),
    .clr_addr (g_rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .hazard   (hazard)
  );

endmodule
